// File: rtl/battleship_pkg.sv
// Shared types and defaults for the battleship command host.
package battleship_pkg;

   localparam int unsigned DATA_W         = 12;
   localparam int unsigned BOARD_SIZE_DEF = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      ST_OK        = 2'b00,
      ST_TIMEOUT   = 2'b01,
      ST_RANGE_ERR = 2'b10
   } status_t;

   typedef struct packed {
      logic       player;
      logic       direction;
      logic [3:0] row;
      logic [3:0] col;
   } cmd_t;

   // True when both coordinates fall on a board of the given size.
   function automatic logic cmd_in_range(cmd_t c, int unsigned board_size);
      return (32'(c.row) < board_size) && (32'(c.col) < board_size);
   endfunction

endpackage

// File: rtl/battleship_cmd_fifo.sv
// Command FIFO; pointers carry one extra wrap bit to tell full from empty.
module battleship_cmd_fifo
   import battleship_pkg::*;
#(
   parameter int unsigned CMD_DEPTH = 4,
   parameter type         T         = cmd_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = $clog2(CMD_DEPTH);

   T              mem [CMD_DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          do_push;
   logic          do_pop;

   // Push is gated on full alone, so a same-cycle pop never frees a slot early.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q[AW-1:0]] <= din;
      end
   end

   // Status flags and head-of-queue read.
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      dout  = mem[rd_ptr_q[AW-1:0]];
   end

endmodule

// File: rtl/battleship_cmd_host.sv
// Queues commands, issues them to the battleship core and returns results.
module battleship_cmd_host
   import battleship_pkg::*;
#(
   parameter int unsigned CMD_DEPTH  = 4,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned BOARD_SIZE = BOARD_SIZE_DEF
) (
   input  logic              ph1,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_player,
   input  logic              cmd_direction,
   input  logic [3:0]        cmd_row,
   input  logic [3:0]        cmd_col,
   output logic              core_read,
   output logic              core_player,
   output logic              core_direction,
   output logic [3:0]        core_row,
   output logic [3:0]        core_col,
   input  logic [DATA_W-1:0] core_data_out,
   input  logic              core_data_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_status,
   output logic              busy,
   output logic              spurious
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   cmd_t              cmd_q, cmd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   status_t           rsp_status_q, rsp_status_d;
   logic              spurious_q, spurious_d;

   cmd_t              fifo_din;
   cmd_t              fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;

   assign fifo_din = '{player: cmd_player, direction: cmd_direction, row: cmd_row, col: cmd_col};

   battleship_cmd_fifo #(
      .CMD_DEPTH (CMD_DEPTH),
      .T         (cmd_t)
   ) u_fifo (
      .clk   (ph1),
      .rst_n (reset_n),
      .push  (cmd_valid),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state logic for the command sequencer.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      cnt_d        = cnt_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      fifo_pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_dout;
               if (cmd_in_range(fifo_dout, BOARD_SIZE)) begin
                  state_d = ISSUE;
               end else begin
                  // Out-of-board commands never reach the core.
                  rsp_data_d   = '0;
                  rsp_status_d = ST_RANGE_ERR;
                  state_d      = RESP;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Data takes priority over a timeout landing on the same cycle.
            if (core_data_ready) begin
               rsp_data_d   = core_data_out;
               rsp_status_d = ST_OK;
               state_d      = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rsp_data_d   = '0;
               rsp_status_d = ST_TIMEOUT;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sticky flag for results arriving when nothing is outstanding.
   always_comb begin
      spurious_d = spurious_q | (core_data_ready && (state_q != WAIT));
   end

   // Sequencer state and captured command/response registers.
   always_ff @(posedge ph1 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cmd_q        <= '0;
         cnt_q        <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= ST_OK;
         spurious_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         cnt_q        <= cnt_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
         spurious_q   <= spurious_d;
      end
   end

   // Outputs decoded from registered state, so reset clears them immediately.
   always_comb begin
      cmd_ready      = !fifo_full;
      core_read      = (state_q == ISSUE);
      core_player    = cmd_q.player;
      core_direction = cmd_q.direction;
      core_row       = cmd_q.row;
      core_col       = cmd_q.col;
      rsp_valid      = (state_q == RESP);
      rsp_data       = rsp_data_q;
      rsp_status     = rsp_status_q;
      busy           = (state_q != IDLE) || !fifo_empty;
      spurious       = spurious_q;
   end

endmodule

// File: tb/tb_battleship_cmd_host.sv
// Scoreboard bench for battleship_cmd_host with a simple behavioural core.
module tb_battleship_cmd_host;
   import battleship_pkg::*;

   logic        ph1 = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_player = 1'b0;
   logic        cmd_direction = 1'b0;
   logic [3:0]  cmd_row = '0;
   logic [3:0]  cmd_col = '0;
   logic        core_read;
   logic        core_player;
   logic        core_direction;
   logic [3:0]  core_row;
   logic [3:0]  core_col;
   logic [11:0] core_data_out;
   logic        core_data_ready;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [11:0] rsp_data;
   logic [1:0]  rsp_status;
   logic        busy;
   logic        spurious;

   battleship_cmd_host dut (
      .ph1             (ph1),
      .reset_n         (reset_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_player      (cmd_player),
      .cmd_direction   (cmd_direction),
      .cmd_row         (cmd_row),
      .cmd_col         (cmd_col),
      .core_read       (core_read),
      .core_player     (core_player),
      .core_direction  (core_direction),
      .core_row        (core_row),
      .core_col        (core_col),
      .core_data_out   (core_data_out),
      .core_data_ready (core_data_ready),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .rsp_status      (rsp_status),
      .busy            (busy),
      .spurious        (spurious)
   );

   always #5 ph1 = ~ph1;

   typedef struct {
      logic [11:0] data;
      logic [1:0]  status;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   read_pulses = 0;

   // Behavioural core: answers core_read after core_delay cycles when enabled.
   logic        rdy_model = 1'b0;
   logic        rdy_force = 1'b0;
   logic [11:0] data_model = '0;
   bit          core_en = 1'b1;
   bit          fixed_en = 1'b0;
   logic [11:0] fixed_data = '0;
   int          core_delay = 2;
   int          countdown = -1;

   assign core_data_ready = rdy_model | rdy_force;
   assign core_data_out   = data_model;

   function automatic logic [11:0] core_model(logic p, logic d, logic [3:0] r, logic [3:0] c);
      return {r, c, p, d, 2'b01};
   endfunction

   always @(posedge ph1) begin
      #1;
      rdy_model = 1'b0;
      if (!reset_n) begin
         countdown = -1;
      end else begin
         if (countdown == 0) begin
            rdy_model = 1'b1;
            countdown = -1;
         end else if (countdown > 0) begin
            countdown--;
         end
         if (core_read && core_en) begin
            countdown  = core_delay - 1;
            data_model = fixed_en ? fixed_data
                                  : core_model(core_player, core_direction, core_row, core_col);
         end
      end
   end

   always @(negedge ph1) begin
      if (core_read) read_pulses++;
   end

   // Response monitor: pops the scoreboard on every handshake.
   always @(negedge ph1) begin
      if (reset_n && rsp_valid && rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected: got data=%h status=%b, required no response",
                     rsp_data, rsp_status);
         end else begin
            mon_e = exp_q.pop_front();
            if (rsp_data !== mon_e.data || rsp_status !== mon_e.status) begin
               failures++;
               $display("FAIL rsp_compare: got data=%h status=%b, required data=%h status=%b",
                        rsp_data, rsp_status, mon_e.data, mon_e.status);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic p, input logic d, input logic [3:0] r,
                           input logic [3:0] c, input logic [1:0] st);
      exp_t e;
      int   n;
      cmd_player    = p;
      cmd_direction = d;
      cmd_row       = r;
      cmd_col       = c;
      cmd_valid     = 1'b1;
      n = 0;
      @(negedge ph1);
      while (!cmd_ready && n < 400) begin
         n++;
         @(negedge ph1);
      end
      checks++;
      if (!cmd_ready) begin
         failures++;
         $display("FAIL send_accept: cmd_ready=%b, required 1 within 400 cycles", cmd_ready);
      end
      @(posedge ph1);
      e.data   = (st == ST_OK) ? core_model(p, d, r, c) : 12'h000;
      e.status = st;
      exp_q.push_back(e);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge ph1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      end
      repeat (2) @(negedge ph1);
   endtask

   task automatic wait_core_read(output bit seen);
      int n = 0;
      do begin
         @(negedge ph1);
         n++;
      end while (!core_read && n < 20);
      seen = core_read;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL core_read_seen: core_read=%b, required 1 within 20 cycles", core_read);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
      end
      checks++;
      if ({core_read, rsp_valid, busy, spurious} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got read/valid/busy/spur=%b required 0000",
                  {core_read, rsp_valid, busy, spurious});
      end
      checks++;
      if ({rsp_data, rsp_status} !== 14'h0) begin
         failures++; $display("FAIL reset_rsp: got %h required 0", {rsp_data, rsp_status});
      end
      checks++;
      if ({core_player, core_direction, core_row, core_col} !== 10'h0) begin
         failures++;
         $display("FAIL reset_core_fields: got %h required 0",
                  {core_player, core_direction, core_row, core_col});
      end
      @(negedge ph1);
      reset_n = 1'b1;
      @(posedge ph1);
      #1;
   endtask

   task automatic test_basic();
      exp_t e;
      int   p0 = read_pulses;
      rsp_ready  = 1'b1;
      fixed_en   = 1'b1;
      fixed_data = 12'hA5C;
      cmd_player = 1'b0; cmd_direction = 1'b1; cmd_row = 4'd3; cmd_col = 4'd4;
      cmd_valid  = 1'b1;
      @(negedge ph1);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++; $display("FAIL basic_ready: got %b required 1", cmd_ready);
      end
      @(posedge ph1);
      e.data = 12'hA5C; e.status = ST_OK;
      exp_q.push_back(e);
      #1 cmd_valid = 1'b0;
      @(negedge ph1);
      checks++;
      if (core_read !== 1'b0) begin
         failures++; $display("FAIL basic_read_k: got %b required 0", core_read);
      end
      @(negedge ph1);
      checks++;
      if (core_read !== 1'b1) begin
         failures++; $display("FAIL basic_read_k1: got %b required 1", core_read);
      end
      checks++;
      if ({core_player, core_direction, core_row, core_col} !== {1'b0, 1'b1, 4'd3, 4'd4}) begin
         failures++;
         $display("FAIL basic_fields: got %h required %h",
                  {core_player, core_direction, core_row, core_col}, {1'b0, 1'b1, 4'd3, 4'd4});
      end
      @(negedge ph1);
      checks++;
      if (core_read !== 1'b0) begin
         failures++; $display("FAIL basic_read_k2: got %b required 0", core_read);
      end
      wait_drain(50);
      checks++;
      if (read_pulses != p0 + 1) begin
         failures++; $display("FAIL basic_pulses: got %0d required %0d", read_pulses - p0, 1);
      end
      fixed_en = 1'b0;
      @(posedge ph1);
      #1;
   endtask

   task automatic test_range();
      int p0 = read_pulses;
      send_cmd(1'b0, 1'b0, 4'd10, 4'd2, ST_RANGE_ERR);
      send_cmd(1'b1, 1'b0, 4'd5, 4'd9, ST_OK);
      send_cmd(1'b0, 1'b1, 4'd2, 4'd15, ST_RANGE_ERR);
      send_cmd(1'b1, 1'b1, 4'd9, 4'd9, ST_OK);
      wait_drain(100);
      checks++;
      if (read_pulses != p0 + 2) begin
         failures++; $display("FAIL range_pulses: got %0d required %0d", read_pulses - p0, 2);
      end
      @(posedge ph1);
      #1;
   endtask

   task automatic timeout_case(input bit with_data);
      bit seen;
      core_en    = with_data;
      core_delay = 255;
      if (with_data) send_cmd(1'b1, 1'b1, 4'd7, 4'd8, ST_OK);
      else           send_cmd(1'b0, 1'b0, 4'd1, 4'd1, ST_TIMEOUT);
      wait_core_read(seen);
      for (int i = 1; i <= 256; i++) begin
         @(negedge ph1);
         if (i == 255) begin
            checks++;
            if (rsp_valid !== 1'b0) begin
               failures++; $display("FAIL timeout_early(%0d): rsp_valid=%b required 0",
                                    with_data, rsp_valid);
            end
         end
         if (i == 256) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_status !== (with_data ? 2'b00 : 2'b01)) begin
               failures++;
               $display("FAIL timeout_edge(%0d): valid=%b status=%b required 1 %b", with_data,
                        rsp_valid, rsp_status, with_data ? 2'b00 : 2'b01);
            end
         end
      end
      wait_drain(20);
      core_en    = 1'b1;
      core_delay = 2;
      @(posedge ph1);
      #1;
   endtask

   task automatic test_timeout();
      timeout_case(1'b0);
      timeout_case(1'b1);
   endtask

   task automatic test_back_to_back();
      logic [11:0] first = core_model(1'b0, 1'b1, 4'd0, 4'd5);
      rsp_ready = 1'b0;
      send_cmd(1'b0, 1'b1, 4'd0, 4'd5, ST_OK);
      send_cmd(1'b1, 1'b0, 4'd1, 4'd6, ST_OK);
      send_cmd(1'b0, 1'b0, 4'd2, 4'd7, ST_OK);
      send_cmd(1'b1, 1'b1, 4'd3, 4'd8, ST_OK);
      send_cmd(1'b0, 1'b1, 4'd4, 4'd9, ST_OK);
      cmd_player = 1'b1; cmd_direction = 1'b1; cmd_row = 4'd6; cmd_col = 4'd6;
      cmd_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge ph1);
         checks++;
         if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full[%0d]: cmd_ready=%b busy=%b required 0 1", i, cmd_ready, busy);
         end
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== first || rsp_status !== 2'b00) begin
            failures++;
            $display("FAIL b2b_hold[%0d]: valid=%b data=%h status=%b required 1 %h 00",
                     i, rsp_valid, rsp_data, rsp_status, first);
         end
      end
      @(posedge ph1);
      #1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_drain(200);
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_idle: busy=%b cmd_ready=%b required 0 1", busy, cmd_ready);
      end
      @(posedge ph1);
      #1;
   endtask

   task automatic test_spurious_reset();
      bit seen;
      rsp_ready = 1'b1;
      checks++;
      if (spurious !== 1'b0) begin
         failures++; $display("FAIL spur_initial: got %b required 0", spurious);
      end
      rdy_force = 1'b1;
      @(posedge ph1);
      #1 rdy_force = 1'b0;
      @(negedge ph1);
      checks++;
      if (spurious !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL spur_set: spurious=%b rsp_valid=%b required 1 0", spurious, rsp_valid);
      end
      repeat (5) @(negedge ph1);
      checks++;
      if (spurious !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL spur_sticky: spurious=%b rsp_valid=%b busy=%b required 1 0 0",
                  spurious, rsp_valid, busy);
      end
      // Reset while waiting on a silent core.
      @(posedge ph1);
      #1;
      core_en = 1'b0;
      send_cmd(1'b1, 1'b0, 4'd4, 4'd4, ST_TIMEOUT);
      wait_core_read(seen);
      repeat (3) @(negedge ph1);
      #2 reset_n = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      if ({core_read, rsp_valid, busy, cmd_ready, spurious} !== 5'b00010) begin
         failures++;
         $display("FAIL reset_wait: read/valid/busy/ready/spur=%b required 00010",
                  {core_read, rsp_valid, busy, cmd_ready, spurious});
      end
      @(negedge ph1);
      #2 reset_n = 1'b1;
      // Reset while the strobe is high.
      @(posedge ph1);
      #1;
      send_cmd(1'b0, 1'b0, 4'd8, 4'd1, ST_TIMEOUT);
      wait_core_read(seen);
      #2 reset_n = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      if (core_read !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_issue: core_read=%b busy=%b required 0 0", core_read, busy);
      end
      @(negedge ph1);
      #2 reset_n = 1'b1;
      repeat (5) @(negedge ph1);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_quiet: rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
      end
      core_en = 1'b1;
      @(posedge ph1);
      #1;
      send_cmd(1'b1, 1'b0, 4'd6, 4'd2, ST_OK);
      wait_drain(50);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_range();
      test_timeout();
      test_back_to_back();
      test_spurious_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
